// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard/stall sequencer for the 5-stage pipeline.
//  Detects RAW hazards between ID sources and EXE/MEM destinations, gates branch
//  flushes, freezes the pipeline while the data SRAM is busy and counts stalls/flushes.
//  Ports:
//   clk, rst (async, active-low)
//   forward_en                       forwarding present: only load-use hazards stall
//   ID_src1, ID_src2, ID_two_src     ID-stage source registers
//   Br_taken                         ID branch resolved taken
//   EXE_dest, EXE_WB_en, EXE_MEM_R_en EXE-stage destination info
//   MEM_dest, MEM_WB_en, MEM_access  MEM-stage destination info / memory access
//   mem_ready                        SRAM access complete
//   hazard_detected, freeze_PC, freeze_IF_ID, flush_IF_ID, freeze_all  pipeline control
//   mem_err                          sticky SRAM timeout
//   stall_cnt, flush_cnt             saturating performance counters
module pipeline_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic [REG_ADDR_W-1:0] ID_src1,
    input  logic [REG_ADDR_W-1:0] ID_src2,
    input  logic                  ID_two_src,
    input  logic                  Br_taken,
    input  logic [REG_ADDR_W-1:0] EXE_dest,
    input  logic                  EXE_WB_en,
    input  logic                  EXE_MEM_R_en,
    input  logic [REG_ADDR_W-1:0] MEM_dest,
    input  logic                  MEM_WB_en,
    input  logic                  MEM_access,
    input  logic                  mem_ready,
    output logic                  hazard_detected,
    output logic                  freeze_PC,
    output logic                  freeze_IF_ID,
    output logic                  flush_IF_ID,
    output logic                  freeze_all,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);
    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          run, raw_exe, raw_mem, raw;

    // Register 0 is hardwired, so a zero destination never creates a hazard
    assign raw_exe = EXE_WB_en & (((ID_src1 == EXE_dest) & (EXE_dest != '0)) |
                                  (ID_two_src & (ID_src2 == EXE_dest) & (EXE_dest != '0)));
    assign raw_mem = MEM_WB_en & (((ID_src1 == MEM_dest) & (MEM_dest != '0)) |
                                  (ID_two_src & (ID_src2 == MEM_dest) & (MEM_dest != '0)));
    assign raw     = forward_en ? (raw_exe & EXE_MEM_R_en) : (raw_exe | raw_mem);
    assign run     = (state == RUN);

    assign hazard_detected = raw & run;
    assign freeze_all      = !run | (MEM_access & !mem_ready);
    assign freeze_PC       = hazard_detected | freeze_all;
    assign freeze_IF_ID    = freeze_PC;
    // A branch resolved on stale operands must not redirect fetch
    assign flush_IF_ID     = Br_taken & !hazard_detected & run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                RUN: if (MEM_access & !mem_ready) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= WW'(1);
                end
                MEM_WAIT: if (mem_ready) begin
                    state <= RUN;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    state   <= ERR;
                    mem_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
                default: begin
                    state   <= ERR;
                    mem_err <= 1'b1;
                end
            endcase
            if (freeze_PC && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_IF_ID && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed vector table plus multi-cycle sequences for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       forward_en, ID_two_src, Br_taken, EXE_WB_en, EXE_MEM_R_en;
    logic       MEM_WB_en, MEM_access, mem_ready;
    logic [4:0] ID_src1, ID_src2, EXE_dest, MEM_dest;

    logic        hz, fpc, fif, fl, fa, merr;
    logic [31:0] stall_cnt, flush_cnt;
    logic        hz4, fpc4, fif4, fl4, fa4, merr4;
    logic [3:0]  stall4, flush4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_two_src(ID_two_src), .Br_taken(Br_taken), .EXE_dest(EXE_dest), .EXE_WB_en(EXE_WB_en),
        .EXE_MEM_R_en(EXE_MEM_R_en), .MEM_dest(MEM_dest), .MEM_WB_en(MEM_WB_en),
        .MEM_access(MEM_access), .mem_ready(mem_ready), .hazard_detected(hz), .freeze_PC(fpc),
        .freeze_IF_ID(fif), .flush_IF_ID(fl), .freeze_all(fa), .mem_err(merr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .forward_en(forward_en), .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_two_src(ID_two_src), .Br_taken(Br_taken), .EXE_dest(EXE_dest), .EXE_WB_en(EXE_WB_en),
        .EXE_MEM_R_en(EXE_MEM_R_en), .MEM_dest(MEM_dest), .MEM_WB_en(MEM_WB_en),
        .MEM_access(MEM_access), .mem_ready(mem_ready), .hazard_detected(hz4), .freeze_PC(fpc4),
        .freeze_IF_ID(fif4), .flush_IF_ID(fl4), .freeze_all(fa4), .mem_err(merr4),
        .stall_cnt(stall4), .flush_cnt(flush4)
    );

    typedef struct {
        logic       fw;
        logic [4:0] s1, s2;
        logic       two, br;
        logic [4:0] ed;
        logic       ewb, er;
        logic [4:0] md;
        logic       mwb, macc, rdy;
        logic       hz, fl, fa;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        forward_en   = x.fw;
        ID_src1      = x.s1;
        ID_src2      = x.s2;
        ID_two_src   = x.two;
        Br_taken     = x.br;
        EXE_dest     = x.ed;
        EXE_WB_en    = x.ewb;
        EXE_MEM_R_en = x.er;
        MEM_dest     = x.md;
        MEM_WB_en    = x.mwb;
        MEM_access   = x.macc;
        mem_ready    = x.rdy;
    endtask

    task automatic idle();
        drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    endtask

    initial begin
        logic [31:0] f0, s0;
        //        fw s1 s2 two br ed ewb er md mwb macc rdy  hz fl fa
        v[0]  = '{0, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1,  1, 0, 0};
        v[1]  = '{0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0};
        v[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0};
        v[3]  = '{1, 1, 5, 1, 0, 5, 1, 0, 0, 0, 0, 1,  0, 0, 0};
        v[4]  = '{1, 1, 5, 1, 0, 5, 1, 1, 0, 0, 0, 1,  1, 0, 0};
        v[5]  = '{1, 1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 1,  0, 0, 0};
        v[6]  = '{0, 7, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1,  1, 0, 0};
        v[7]  = '{1, 7, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1,  0, 0, 0};
        v[8]  = '{0, 7, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1,  0, 0, 0};
        v[9]  = '{0, 1, 9, 1, 0, 0, 0, 0, 9, 1, 0, 1,  1, 0, 0};
        v[10] = '{0, 3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1,  0, 0, 0};
        v[11] = '{0, 2, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1,  0, 1, 0};
        v[12] = '{0, 3, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1,  1, 0, 0};
        v[13] = '{0, 2, 0, 0, 0, 3, 1, 0, 0, 0, 1, 1,  0, 0, 0};

        idle();
        #12;
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_flush_cnt", flush_cnt, 0);
        chk("reset_mem_err", merr, 0);
        chk("reset_freeze_all", fa, 0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(v[i]);
            #1;
            chk($sformatf("vec%0d_hazard", i), hz, v[i].hz);
            chk($sformatf("vec%0d_freeze_PC", i), fpc, v[i].hz | v[i].fa);
            chk($sformatf("vec%0d_freeze_IF_ID", i), fif, v[i].hz | v[i].fa);
            chk($sformatf("vec%0d_flush", i), fl, v[i].fl);
            chk($sformatf("vec%0d_freeze_all", i), fa, v[i].fa);
        end

        // branch on stale operands suppressed, then honoured once the hazard clears
        @(negedge clk);
        idle();
        ID_src1 = 3; EXE_dest = 3; EXE_WB_en = 1; Br_taken = 1;
        f0 = flush_cnt;
        #1 chk("br_raw_flush", fl, 0);
        @(negedge clk);
        EXE_WB_en = 0;
        #1 chk("br_clear_flush", fl, 1);
        @(negedge clk);
        chk("br_flush_cnt", flush_cnt, f0 + 1);
        idle();

        // 3 not-ready cycles then ready: 4 frozen cycles
        @(negedge clk);
        s0 = stall_cnt;
        MEM_access = 1; mem_ready = 0;
        #1 chk("mw0_freeze_all", fa, 1);
        chk("mw0_hazard", hz, 0);
        @(negedge clk);
        ID_src1 = 3; EXE_dest = 3; EXE_WB_en = 1; Br_taken = 1;
        #1 chk("mw1_freeze_all", fa, 1);
        chk("mw1_hazard_forced", hz, 0);
        chk("mw1_flush_forced", fl, 0);
        @(negedge clk);
        #1 chk("mw2_freeze_all", fa, 1);
        @(negedge clk);
        mem_ready = 1;
        #1 chk("mw3_freeze_all", fa, 1);
        chk("mw3_hazard_forced", hz, 0);
        chk("mw3_freeze_PC", fpc, 1);
        @(negedge clk);
        chk("mw_stall_cnt", stall_cnt, s0 + 4);
        #1 chk("mw_back_run_freeze_all", fa, 0);
        chk("mw_back_run_hazard", hz, 1);
        idle();

        // asynchronous reset clears counters without a clock edge
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("areset_stall_cnt", stall_cnt, 0);
        chk("areset_flush_cnt", flush_cnt, 0);
        @(negedge clk) rst = 1'b1;

        // timeout: mem_err after 16 stalled cycles, sticky
        MEM_access = 1; mem_ready = 0;
        for (int k = 0; k < 16; k++) begin
            #1 chk($sformatf("to_cycle%0d_mem_err", k), merr, 0);
            @(negedge clk);
        end
        chk("to_mem_err", merr, 1);
        chk("to_stall_cnt", stall_cnt, 16);
        chk("to_stall_cnt_sat4", stall4, 15);
        mem_ready = 1;
        ID_src1 = 3; EXE_dest = 3; EXE_WB_en = 1; Br_taken = 1;
        #1 chk("err_freeze_all", fa, 1);
        chk("err_hazard_forced", hz, 0);
        chk("err_flush_forced", fl, 0);
        @(negedge clk);
        chk("err_mem_err_sticky", merr, 1);
        chk("err_stall_cnt", stall_cnt, 17);
        chk("err_stall_cnt_sat4", stall4, 15);
        idle();

        // reset from ERR, then reset in the middle of a memory wait
        #2 rst = 1'b0;
        MEM_access = 1;
        #1 chk("rst_err_mem_err", merr, 0);
        chk("rst_err_freeze_all", fa, 0);
        @(negedge clk) rst = 1'b1;
        mem_ready = 0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("wait_freeze_all", fa, 1);
        rst = 1'b0;
        mem_ready = 1;
        #1 chk("midwait_freeze_all", fa, 0);
        chk("midwait_mem_err", merr, 0);
        chk("midwait_stall_cnt", stall_cnt, 0);
        chk("midwait_stall_cnt4", stall4, 0);
        chk("midwait_flush_cnt", flush_cnt, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("post_reset_stall_cnt", stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
